// File: rtl/mpu_pkg.sv
// Shared types and constants for the memory protection unit.
package mpu_pkg;

    typedef enum logic [2:0] {
        CAUSE_NONE   = 3'd0,
        CAUSE_BRANCH = 3'd1,
        CAUSE_JUMP   = 3'd2,
        CAUSE_READ   = 3'd3,
        CAUSE_WRITE  = 3'd4,
        CAUSE_CFG    = 3'd5
    } mpu_cause_e;

    // Bit positions within a 3-bit {X,R,W} permission entry
    localparam int PERM_X = 2;
    localparam int PERM_R = 1;
    localparam int PERM_W = 0;

    // Region 0 is kernel-only out of reset; all other regions are open
    localparam logic [2:0] PERM_RST_R0  = 3'b000;
    localparam logic [2:0] PERM_RST_DEF = 3'b111;

endpackage

// File: rtl/mem_protect_unit_if.sv
// Fault reporting handshake between the protection unit and the exception unit.
interface mem_protect_unit_if
    import mpu_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              fault_valid;
    mpu_cause_e        fault_cause;
    logic [ADDR_W-1:0] fault_addr;
    logic              fault_ack;

    modport master (output fault_valid, fault_cause, fault_addr, input fault_ack);
    modport slave  (input fault_valid, fault_cause, fault_addr, output fault_ack);
endinterface

// File: rtl/mpu_perm_table.sv
// Per-region user permission table: one sync write port, three async read ports.
module mpu_perm_table
    import mpu_pkg::*;
#(
    parameter int REGION_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [REGION_BITS-1:0] waddr,
    input  logic [2:0]             wdata,
    input  logic [REGION_BITS-1:0] br_region,
    input  logic [REGION_BITS-1:0] jp_region,
    input  logic [REGION_BITS-1:0] dt_region,
    output logic                   br_x,
    output logic                   jp_x,
    output logic                   dt_r,
    output logic                   dt_w
);
    localparam int NUM_REGIONS = 1 << REGION_BITS;

    logic [NUM_REGIONS-1:0][2:0] perm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGIONS; i++)
                perm[i] <= (i == 0) ? PERM_RST_R0 : PERM_RST_DEF;
        end else if (we) begin
            perm[waddr] <= wdata;
        end
    end

    // Reads see the pre-write contents in the cycle of a write
    assign br_x = perm[br_region][PERM_X];
    assign jp_x = perm[jp_region][PERM_X];
    assign dt_r = perm[dt_region][PERM_R];
    assign dt_w = perm[dt_region][PERM_W];

endmodule

// File: rtl/mem_protect_unit.sv
// User-mode jump/branch/memory legality checker with latched fault reporting
// and a saturating fault counter.
module mem_protect_unit
    import mpu_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int REGION_BITS = 4,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic                   jump,
    input  logic                   miss,
    input  logic [ADDR_W-1:0]      new_pc,
    input  logic [ADDR_W-1:0]      branch_pc,
    input  logic                   memre,
    input  logic                   memwe,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic                   cfg_we,
    input  logic [REGION_BITS-1:0] cfg_region,
    input  logic [2:0]             cfg_perm,
    output logic                   jump_out,
    output logic                   miss_out,
    output logic                   mem_block,
    output logic                   fault_overflow,
    output logic [CNT_W-1:0]       fault_count,
    mem_protect_unit_if.master     flt
);
    logic user;
    logic br_x, jp_x, dt_r, dt_w;
    logic ill_miss, ill_jump, ill_rd, ill_wr, ill_cfg;
    logic any_fault, pending, ack_cycle;

    mpu_cause_e        det_cause;
    logic [ADDR_W-1:0] det_addr;

    logic              valid_q, valid_d;
    mpu_cause_e        cause_q, cause_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q;

    assign user = ~mode;

    mpu_perm_table #(.REGION_BITS(REGION_BITS)) u_perm (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (cfg_we & mode),
        .waddr     (cfg_region),
        .wdata     (cfg_perm),
        .br_region (branch_pc[ADDR_W-1 -: REGION_BITS]),
        .jp_region (new_pc[ADDR_W-1 -: REGION_BITS]),
        .dt_region (mem_addr[ADDR_W-1 -: REGION_BITS]),
        .br_x      (br_x),
        .jp_x      (jp_x),
        .dt_r      (dt_r),
        .dt_w      (dt_w)
    );

    assign ill_miss = user & miss  & ~br_x;
    assign ill_jump = user & jump  & ~jp_x;
    assign ill_rd   = user & memre & ~dt_r;
    assign ill_wr   = user & memwe & ~dt_w;
    assign ill_cfg  = user & cfg_we;

    assign jump_out  = jump & ~ill_jump;
    assign miss_out  = miss & ~ill_miss;
    assign mem_block = ill_rd | ill_wr;

    // Highest-priority fault only: BRANCH > JUMP > WRITE > READ > CFG
    always_comb begin
        det_cause = CAUSE_NONE;
        det_addr  = '0;
        if (ill_miss) begin
            det_cause = CAUSE_BRANCH;
            det_addr  = branch_pc;
        end else if (ill_jump) begin
            det_cause = CAUSE_JUMP;
            det_addr  = new_pc;
        end else if (ill_wr) begin
            det_cause = CAUSE_WRITE;
            det_addr  = mem_addr;
        end else if (ill_rd) begin
            det_cause = CAUSE_READ;
            det_addr  = mem_addr;
        end else if (ill_cfg) begin
            det_cause = CAUSE_CFG;
            det_addr  = {{(ADDR_W-REGION_BITS){1'b0}}, cfg_region};
        end
    end

    assign any_fault = (det_cause != CAUSE_NONE);
    assign pending   = valid_q & ~flt.fault_ack;
    assign ack_cycle = valid_q & flt.fault_ack;

    always_comb begin
        valid_d = valid_q;
        cause_d = cause_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q;
        if (pending) begin
            // Unacknowledged fault keeps its cause/addr; new ones are dropped
            if (any_fault) ovf_d = 1'b1;
        end else if (any_fault) begin
            valid_d = 1'b1;
            cause_d = det_cause;
            addr_d  = det_addr;
        end else begin
            valid_d = 1'b0;
            if (ack_cycle) ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            cause_q <= CAUSE_NONE;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cause_q <= cause_d;
            addr_q  <= addr_d;
            ovf_q   <= ovf_d;
            if (any_fault && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign flt.fault_valid = valid_q;
    assign flt.fault_cause = cause_q;
    assign flt.fault_addr  = addr_q;
    assign fault_overflow  = ovf_q;
    assign fault_count     = cnt_q;

endmodule

// File: tb/tb_mem_protect_unit.sv
// Scoreboard bench for mem_protect_unit: main instance (CNT_W=8) plus a CNT_W=2 copy.
module tb_mem_protect_unit;
    import mpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, mode, jump, miss, memre, memwe, cfg_we, ack;
    logic [15:0] new_pc, branch_pc, mem_addr;
    logic [3:0]  cfg_region;
    logic [2:0]  cfg_perm;

    logic       jo_a, mo_a, mb_a, ovf_a;
    logic [7:0] cnt_a;
    logic       jo_b, mo_b, mb_b, ovf_b;
    logic [1:0] cnt_b;

    mem_protect_unit_if #(.ADDR_W(16)) flt_a ();
    mem_protect_unit_if #(.ADDR_W(16)) flt_b ();
    assign flt_a.fault_ack = ack;
    assign flt_b.fault_ack = ack;

    mem_protect_unit #(.ADDR_W(16), .REGION_BITS(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode), .jump(jump), .miss(miss),
        .new_pc(new_pc), .branch_pc(branch_pc), .memre(memre), .memwe(memwe),
        .mem_addr(mem_addr), .cfg_we(cfg_we), .cfg_region(cfg_region), .cfg_perm(cfg_perm),
        .jump_out(jo_a), .miss_out(mo_a), .mem_block(mb_a),
        .fault_overflow(ovf_a), .fault_count(cnt_a), .flt(flt_a.master)
    );

    mem_protect_unit #(.ADDR_W(16), .REGION_BITS(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode), .jump(jump), .miss(miss),
        .new_pc(new_pc), .branch_pc(branch_pc), .memre(memre), .memwe(memwe),
        .mem_addr(mem_addr), .cfg_we(cfg_we), .cfg_region(cfg_region), .cfg_perm(cfg_perm),
        .jump_out(jo_b), .miss_out(mo_b), .mem_block(mb_b),
        .fault_overflow(ovf_b), .fault_count(cnt_b), .flt(flt_b.master)
    );

    typedef struct {
        logic        jo, mo, mb, fv, fo;
        logic [2:0]  fc;
        logic [15:0] fa;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] sb_b[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        mode = 1'b0; jump = 1'b0; miss = 1'b0; memre = 1'b0; memwe = 1'b0;
        cfg_we = 1'b0; ack = 1'b0;
        new_pc = '0; branch_pc = '0; mem_addr = '0; cfg_region = '0; cfg_perm = '0;
    endtask

    // Entered at negedge with inputs driven; checks comb outputs, then the
    // registered state after the next posedge; returns at the following negedge.
    task automatic step(input string tag, input logic ejo, input logic emo, input logic emb,
                        input logic efv, input logic [2:0] efc, input logic [15:0] efa,
                        input logic efo, input logic [7:0] ecnt);
        exp_t e;
        e.jo = ejo; e.mo = emo; e.mb = emb; e.fv = efv; e.fc = efc;
        e.fa = efa; e.fo = efo; e.cnt = ecnt;
        sb_q.push_back(e);
        #1;
        chk({tag, ".jump_out"},  32'(jo_a), 32'(sb_q[0].jo));
        chk({tag, ".miss_out"},  32'(mo_a), 32'(sb_q[0].mo));
        chk({tag, ".mem_block"}, 32'(mb_a), 32'(sb_q[0].mb));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".valid"}, 32'(flt_a.fault_valid), 32'(e.fv));
        chk({tag, ".cause"}, 32'(flt_a.fault_cause), 32'(e.fc));
        chk({tag, ".addr"},  32'(flt_a.fault_addr),  32'(e.fa));
        chk({tag, ".ovf"},   32'(ovf_a),             32'(e.fo));
        chk({tag, ".count"}, 32'(cnt_a),             32'(e.cnt));
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        idle();
        rst_n = 1'b0;
        step(tag, 0, 0, 0, 0, CAUSE_NONE, 16'h0000, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        do_reset("reset");

        // Jump into kernel-only region 0
        idle(); jump = 1; new_pc = 16'h0123;
        step("t1_jump", 0, 0, 0, 1, CAUSE_JUMP, 16'h0123, 0, 1);
        idle(); ack = 1;
        step("t1_ack", 0, 0, 0, 0, CAUSE_JUMP, 16'h0123, 0, 1);
        idle(); ack = 1;
        step("t1_idle_ack", 0, 0, 0, 0, CAUSE_JUMP, 16'h0123, 0, 1);

        // Branch beats jump
        do_reset("t2_rst");
        idle(); miss = 1; branch_pc = 16'h0040; jump = 1; new_pc = 16'h0050;
        step("t2_prio", 0, 0, 0, 1, CAUSE_BRANCH, 16'h0040, 0, 1);

        // Execute-only region 3
        do_reset("t3_rst");
        idle(); mode = 1; cfg_we = 1; cfg_region = 4'd3; cfg_perm = 3'b100;
        step("t3_cfg", 0, 0, 0, 0, CAUSE_NONE, 16'h0000, 0, 0);
        idle(); memwe = 1; mem_addr = 16'h3000;
        step("t3_wr", 0, 0, 1, 1, CAUSE_WRITE, 16'h3000, 0, 1);
        idle(); ack = 1; memre = 1; mem_addr = 16'h3000;
        step("t3_rd_ack", 0, 0, 1, 1, CAUSE_READ, 16'h3000, 0, 2);
        idle(); ack = 1; jump = 1; new_pc = 16'h3000;
        step("t3_jx", 1, 0, 0, 0, CAUSE_READ, 16'h3000, 0, 2);

        // Overflow while pending
        do_reset("t4_rst");
        idle(); memre = 1; mem_addr = 16'h0100;
        step("t4_first", 0, 0, 1, 1, CAUSE_READ, 16'h0100, 0, 1);
        idle(); memwe = 1; mem_addr = 16'h0200;
        step("t4_second", 0, 0, 1, 1, CAUSE_READ, 16'h0100, 1, 2);
        idle();
        step("t4_hold", 0, 0, 0, 1, CAUSE_READ, 16'h0100, 1, 2);
        idle(); ack = 1;
        step("t4_ack", 0, 0, 0, 0, CAUSE_READ, 16'h0100, 0, 2);

        // User table writes are rejected
        do_reset("t5_rst");
        idle(); cfg_we = 1; cfg_region = 4'd0; cfg_perm = 3'b111;
        step("t5_cfg", 0, 0, 0, 1, CAUSE_CFG, 16'h0000, 0, 1);
        idle(); ack = 1; jump = 1; new_pc = 16'h0000;
        step("t5_jump", 0, 0, 0, 1, CAUSE_JUMP, 16'h0000, 0, 2);
        idle(); ack = 1; mode = 1; jump = 1; new_pc = 16'h0000;
        step("t5_kjump", 1, 0, 0, 0, CAUSE_JUMP, 16'h0000, 0, 2);
        idle(); cfg_we = 1; cfg_region = 4'd9; cfg_perm = 3'b000;
        step("t5_cfg9", 0, 0, 0, 1, CAUSE_CFG, 16'h0009, 0, 3);
        idle(); ack = 1; memre = 1; memwe = 1; mem_addr = 16'h0010;
        step("t5_wr_rd", 0, 0, 1, 1, CAUSE_WRITE, 16'h0010, 0, 4);
        idle(); ack = 1; mode = 1; memwe = 1; mem_addr = 16'h0010;
        step("t5_kwr", 0, 0, 0, 0, CAUSE_WRITE, 16'h0010, 0, 4);

        // Saturation on the narrow-counter instance, then reset mid-fault
        do_reset("t6_rst");
        for (int i = 0; i < 5; i++) begin
            idle(); jump = 1; new_pc = 16'h0000;
            sb_b.push_back((i + 1 > 3) ? 2'd3 : 2'(i + 1));
            step($sformatf("t6_sat%0d", i), 0, 0, 0, 1, CAUSE_JUMP, 16'h0000, (i > 0), 8'(i + 1));
            chk($sformatf("t6_sat%0d.count_b", i), 32'(cnt_b), 32'(sb_b.pop_front()));
        end
        idle(); rst_n = 1'b0; ack = 1; jump = 1; new_pc = 16'h0000;
        step("t6_rst_mid", 0, 0, 0, 0, CAUSE_NONE, 16'h0000, 0, 0);
        chk("t6_rst_mid.valid_b", 32'(flt_b.fault_valid), 32'(0));
        chk("t6_rst_mid.ovf_b",   32'(ovf_b),             32'(0));
        chk("t6_rst_mid.count_b", 32'(cnt_b),             32'(0));
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
